// File: rtl/sa_pkg.sv
// sa_pkg: shared dimensions and controller states for the systolic-array feeder.
package sa_pkg;
  localparam int D_W = 16;
  localparam int S   = 16;
  localparam int C   = 16;
  localparam int K_W = 8;
  typedef enum logic [1:0] {IDLE, PRE, RUN} state_t;
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage shift-enabled delay line; DEPTH=0 is a plain wire.
module skew_line #(
  parameter int D_W   = 16,
  parameter int DEPTH = 1
) (
  input  logic           I_CLK,
  input  logic           I_CLR,
  input  logic           I_SHIFT,
  input  logic [D_W-1:0] I_D,
  output logic [D_W-1:0] O_D
);
  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{I_CLK, I_CLR, I_SHIFT};
    assign O_D = I_D;
  end else begin : g_dl
    logic [D_W-1:0] r_q [DEPTH];
    always_ff @(posedge I_CLK) begin
      if (I_CLR) begin
        for (int n = 0; n < DEPTH; n++) r_q[n] <= '0;
      end else if (I_SHIFT) begin
        r_q[0] <= I_D;
        for (int n = 1; n < DEPTH; n++) r_q[n] <= r_q[n-1];
      end
    end
    assign O_D = r_q[DEPTH-1];
  end
endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: stages k-step X/W vectors and feeds them skewed into a systolic array.
module sa_feeder #(
  parameter int D_W = sa_pkg::D_W,
  parameter int S   = sa_pkg::S,
  parameter int C   = sa_pkg::C,
  parameter int K_W = sa_pkg::K_W
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_GO,
  input  logic [K_W-1:0]   I_K_LEN,
  input  logic             I_VLD,
  output logic             O_RDY,
  input  logic [S*D_W-1:0] I_XCOL,
  input  logic [C*D_W-1:0] I_WROW,
  input  logic             I_SHIFT,
  output logic             O_START_FLAG,
  output logic             O_END_FLAG,
  output logic [S*D_W-1:0] O_X,
  output logic [C*D_W-1:0] O_W,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_UFLOW
);
  import sa_pkg::*;
  localparam int CW = K_W + $clog2(S + C) + 1;
  state_t r_state, w_next;
  logic [K_W-1:0] r_k, r_acc;
  logic [CW-1:0] r_cnt, w_last;
  logic r_full, r_uflow;
  logic [S*D_W-1:0] r_stg_x, r_ox, w_feed_x, w_sx;
  logic [C*D_W-1:0] r_stg_w, r_ow, w_feed_w, w_sw;
  logic w_go, w_sh, w_rdy, w_xfer, w_end, w_clr;
  assign w_last   = CW'(r_k) + CW'(S + C - 2);
  assign w_go     = r_state == IDLE && I_GO && I_K_LEN != '0;
  assign w_sh     = r_state == RUN && I_SHIFT;
  assign w_rdy    = !I_RST && r_state != IDLE && r_acc < r_k && (!r_full || I_SHIFT);
  assign w_xfer   = I_VLD && w_rdy;
  assign w_end    = !I_RST && w_sh && r_cnt + CW'(1) == w_last;
  assign w_clr    = I_RST || w_end;
  assign w_feed_x = r_full ? r_stg_x : '0;
  assign w_feed_w = r_full ? r_stg_w : '0;
  always_comb begin
    w_next = w_go ? PRE : (r_state == PRE && w_xfer) ? RUN : w_end ? IDLE : r_state;
  end
  always_ff @(posedge I_CLK) begin
    r_state <= I_RST ? IDLE : w_next;
  end
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_k     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_uflow <= 1'b0;
      r_stg_x <= '0;
      r_stg_w <= '0;
    end else begin
      if (w_go) begin
        r_k     <= I_K_LEN;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_uflow <= 1'b0;
      end
      if (w_sh) begin
        r_cnt <= r_cnt + CW'(1);
        if (!r_full && r_acc < r_k) r_uflow <= 1'b1;
      end
      if (w_xfer) begin
        r_stg_x <= I_XCOL;
        r_stg_w <= I_WROW;
        r_acc   <= r_acc + K_W'(1);
      end
      // a same-cycle load wins over the shift consuming the old vector
      r_full <= w_xfer || (r_full && !w_sh);
    end
  end
  for (genvar i = 0; i < S; i++) begin : g_x
    skew_line #(.D_W(D_W), .DEPTH(i)) u_line (
      .I_CLK(I_CLK), .I_CLR(w_clr), .I_SHIFT(w_sh),
      .I_D(w_feed_x[i*D_W +: D_W]), .O_D(w_sx[i*D_W +: D_W])
    );
  end
  for (genvar j = 0; j < C; j++) begin : g_w
    skew_line #(.D_W(D_W), .DEPTH(j)) u_line (
      .I_CLK(I_CLK), .I_CLR(w_clr), .I_SHIFT(w_sh),
      .I_D(w_feed_w[j*D_W +: D_W]), .O_D(w_sw[j*D_W +: D_W])
    );
  end
  always_ff @(posedge I_CLK) begin
    if (w_clr) begin
      r_ox <= '0;
      r_ow <= '0;
    end else if (w_sh) begin
      r_ox <= w_sx;
      r_ow <= w_sw;
    end
  end
  assign O_RDY        = w_rdy;
  assign O_START_FLAG = r_state == PRE && w_xfer;
  assign O_END_FLAG   = w_end;
  assign O_DONE       = w_end;
  assign O_BUSY       = r_state != IDLE;
  assign O_UFLOW      = r_uflow;
  assign O_X          = r_ox;
  assign O_W          = r_ow;
endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 Parameters SHALL be: D_W 16, element width (s.2.13 fixed point); S 16, SA rows; C 16, SA columns; K_W 8, width of the k-length field.
REQ-002 I_CLK  in  1  the single clock; all logic rising-edge.
REQ-003 I_RST  in  1  reset, synchronous and active-high.
REQ-004 I_GO  in  1  start pulse; samples I_K_LEN.
REQ-005 I_K_LEN  in  K_W  number of k-steps (inner dimension).
REQ-006 I_VLD / O_RDY  in / out  1  handshake for one k-step vector pair.
REQ-007 I_XCOL  in  S*D_W  X column k; element i in bits [i*D_W +: D_W].
REQ-008 I_WROW  in  C*D_W  W row k; element j in bits [j*D_W +: D_W].
REQ-009 I_SHIFT  in  1  shift pulse from the SA's O_SHIFT.
REQ-010 O_START_FLAG / O_END_FLAG  out  1  one-cycle pulses to the SA's I_START_FLAG / I_END_FLAG.
REQ-011 O_X  out  S*D_W  skewed X to the SA's I_X.
REQ-012 O_W  out  C*D_W  skewed W to the SA's I_W.
REQ-013 O_BUSY  out  1  high outside IDLE.
REQ-014 O_DONE  out  1  one-cycle pulse, coincident with O_END_FLAG.
REQ-015 O_UFLOW  out  1  sticky underflow error, cleared by I_GO or I_RST.

Function
REQ-016 States SHALL be IDLE, PRE, RUN.
REQ-017 IDLE->PRE SHALL occur on I_GO with I_K_LEN!=0, latching K; I_GO with K=0 SHALL be ignored.
REQ-018 PRE->RUN SHALL occur when the staging register first becomes full; O_START_FLAG SHALL pulse on that transition cycle.
REQ-019 RUN->IDLE SHALL occur on the I_SHIFT that makes shift_cnt equal K+S+C-2; O_END_FLAG and O_DONE SHALL pulse in the same cycle.
REQ-020 I_GO SHALL be ignored while O_BUSY=1.
REQ-021 O_RDY SHALL be (PRE or RUN) and acc_cnt<K and (staging empty or I_SHIFT); the combinational dependence on I_SHIFT is intended.
REQ-022 A transfer SHALL occur when I_VLD and O_RDY are both high; it writes staging and increments acc_cnt.
REQ-023 I_VLD while O_RDY=0 SHALL have no effect.
REQ-024 Each I_SHIFT in RUN SHALL advance every delay line one position, consume the staging register and increment shift_cnt.
REQ-025 Consumed data SHALL be the staged vector if full, else zeros.
REQ-026 An I_SHIFT in RUN with staging empty while acc_cnt<K SHALL set O_UFLOW.
REQ-027 Once acc_cnt==K, zeros SHALL be fed (flush); this is not underflow.
REQ-028 An I_SHIFT in IDLE or PRE SHALL be ignored.
REQ-029 Row i of O_X SHALL be delayed i shifts; column j of O_W SHALL be delayed j shifts; row 0 and column 0 have zero delay.
REQ-030 Element k of row i SHALL appear on O_X one cycle after the (k+i+1)-th I_SHIFT.
REQ-031 O_X and O_W SHALL be registered and change only the cycle after an I_SHIFT.
REQ-032 Data SHALL pass bit-exact; no arithmetic is performed on it.
REQ-033 O_X and O_W SHALL return to zero on entry to IDLE.
REQ-034 Simultaneous transfer and I_SHIFT SHALL consume the old staged vector and load the new one in the same cycle.

Reset
REQ-035 On I_RST, the state SHALL go to IDLE and acc_cnt, shift_cnt, staging and all delay lines SHALL be cleared.
REQ-036 On I_RST, every output SHALL be 0.
REQ-037 Reset mid-RUN SHALL abort without an O_END_FLAG or O_DONE pulse.

Structure
REQ-038 Package sa_pkg SHALL hold D_W, S, C, K_W and the state enum.
REQ-039 Sub-module skew_line SHALL be a D_W-wide, parameter-DEPTH delay line with an enable (I_SHIFT), synchronous clear and DEPTH=0 passthrough.
REQ-040 There SHALL be S+C instances of skew_line.

Verification (bench S=C=4, I_SHIFT every 5 cycles)
REQ-041 Scenario: K=1, all X=W=16'h2000 -> START once; O_X[3]=16'h2000 after the 4th shift; END/DONE at the 7th shift.
REQ-042 Scenario: K=3, x[i][k]=16'h0100*i+k -> row 2 shows 0200, 0201, 0202 after shifts 3, 4, 5; zeros otherwise.
REQ-043 Scenario: I_VLD held high, staging full -> O_RDY=0 except in I_SHIFT cycles; exactly K transfers occur.
REQ-044 Scenario: K=4, vector 2 withheld across one shift -> zeros injected; O_UFLOW=1 until the next I_GO.
REQ-045 Scenario: I_RST after shift 3 -> next cycle all outputs 0, IDLE; no END pulse.
REQ-046 Scenario: I_GO with K=0 -> stays IDLE, O_BUSY=0; I_GO during RUN -> K unchanged.
